// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every non-clock/reset signal of the reorder buffer.
//
//   alloc_req / alloc_reg / alloc_ready / alloc_index : issue-side allocation
//   reg_numj / reg_numk / vj / vk / qj / qk           : operand lookups
//   data_bus / valid_bus / RB_index_bus               : FU result buses
//   CDB_data_data / CDB_data_valid                    : per-entry republish
//   commit_valid / commit_reg / commit_data           : in-order commit pulse
//   empty                                             : no entries in flight
//
// Modports: slave = the reorder buffer, master = the core driving it.
//
// Handshake: an entry is granted on a rising clk edge where alloc_req and
// alloc_ready are both high; alloc_index names the granted tag during that
// cycle. alloc_req must not be derived from alloc_ready. A request while
// alloc_ready is low has no effect. alloc_ready depends only on registered
// state. Each valid_bus bit qualifies its data_bus/RB_index_bus slice for the
// current cycle only; there is no back-pressure on results.
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int RB_SIZE   = 8,
  parameter int FU_NUM    = 4,
  parameter int REG_INDEX = 5
);
  logic                          alloc_req;
  logic [REG_INDEX-1:0]          alloc_reg;
  logic                          alloc_ready;
  logic [RB_INDEX-1:0]           alloc_index;
  logic [REG_INDEX-1:0]          reg_numj;
  logic [REG_INDEX-1:0]          reg_numk;
  logic [WORD_SIZE-1:0]          vj;
  logic [WORD_SIZE-1:0]          vk;
  logic [RB_INDEX-1:0]           qj;
  logic [RB_INDEX-1:0]           qk;
  logic [FU_NUM*WORD_SIZE-1:0]   data_bus;
  logic [FU_NUM-1:0]             valid_bus;
  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus;
  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data;
  logic [RB_SIZE-1:0]            CDB_data_valid;
  logic                          commit_valid;
  logic [REG_INDEX-1:0]          commit_reg;
  logic [WORD_SIZE-1:0]          commit_data;
  logic                          empty;

  modport slave (
    input  alloc_req, alloc_reg, reg_numj, reg_numk,
           data_bus, valid_bus, RB_index_bus,
    output alloc_ready, alloc_index, vj, vk, qj, qk,
           CDB_data_data, CDB_data_valid,
           commit_valid, commit_reg, commit_data, empty
  );

  modport master (
    output alloc_req, alloc_reg, reg_numj, reg_numk,
           data_bus, valid_bus, RB_index_bus,
    input  alloc_ready, alloc_index, vj, vk, qj, qk,
           CDB_data_data, CDB_data_valid,
           commit_valid, commit_reg, commit_data, empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer for the Tomasulo core. Allocates entries in program
// order, captures FU results by tag, republishes completed entries on the CDB
// outputs, commits in order into an internal register file and keeps the
// register rename table used for operand lookups.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high
//   bus    : reorder_buffer_if.slave (allocation, lookup, FU results,
//            CDB republish, commit pulse, empty)
//
// Optional build macro: RB_LOOKUP_BYPASS_EN
//   defined   : a lookup of a renamed, not-done register also matches this
//               cycle's FU result buses (lowest FU wins) and returns the value
//   undefined : the tag is returned until the value is registered
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int                 WORD_SIZE = 32,
  parameter int                 RB_INDEX  = 4,
  parameter int                 RB_SIZE   = 8,
  parameter logic [RB_INDEX-1:0] READY    = 4'hF,
  parameter logic [RB_INDEX-1:0] NULL     = 4'hE,
  parameter int                 FU_NUM    = 4,
  parameter int                 REG_INDEX = 5,
  parameter int                 REG_NUM   = 32
) (
  input logic            clk,
  input logic            reset,
  reorder_buffer_if.slave bus
);

  localparam int PTR_W = (RB_SIZE > 1) ? $clog2(RB_SIZE) : 1;
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(RB_SIZE - 1);
  localparam logic [PTR_W:0]      SIZE_CNT = (PTR_W + 1)'(RB_SIZE);
  localparam logic [RB_INDEX-1:0] SIZE_TAG = RB_INDEX'(RB_SIZE);

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [RB_SIZE-1:0]   busy_q, busy_d, done_q, done_d;
  logic [REG_INDEX-1:0] dest_q [RB_SIZE];
  logic [REG_INDEX-1:0] dest_d [RB_SIZE];
  logic [WORD_SIZE-1:0] value_q [RB_SIZE];
  logic [WORD_SIZE-1:0] value_d [RB_SIZE];
  logic [REG_NUM-1:0]   ren_valid_q, ren_valid_d;
  logic [PTR_W-1:0]     ren_tag_q [REG_NUM];
  logic [PTR_W-1:0]     ren_tag_d [REG_NUM];
  logic [WORD_SIZE-1:0] regfile_q [REG_NUM];
  logic [WORD_SIZE-1:0] regfile_d [REG_NUM];
  logic                 commit_valid_q, commit_valid_d;
  logic [REG_INDEX-1:0] commit_reg_q, commit_reg_d;
  logic [WORD_SIZE-1:0] commit_data_q, commit_data_d;

  logic                 alloc_fire, do_commit;
  logic [RB_INDEX-1:0]  fu_tag;
  logic [PTR_W-1:0]     fu_ptr;

  assign bus.alloc_ready    = (count_q < SIZE_CNT);
  assign bus.alloc_index    = RB_INDEX'(tail_q);
  assign bus.empty          = (count_q == '0);
  assign bus.CDB_data_valid = busy_q & done_q;
  assign bus.commit_valid   = commit_valid_q;
  assign bus.commit_reg     = commit_reg_q;
  assign bus.commit_data    = commit_data_q;

  for (genvar e = 0; e < RB_SIZE; e++) begin : g_cdb
    assign bus.CDB_data_data[e*WORD_SIZE +: WORD_SIZE] = value_q[e];
  end

  // Operand lookup on pre-edge state; returns {value, tag}.
  function automatic logic [WORD_SIZE+RB_INDEX-1:0] lookup(input logic [REG_INDEX-1:0] r);
    logic [WORD_SIZE-1:0] v;
    logic [RB_INDEX-1:0]  q;
    logic [PTR_W-1:0]     t;
    v = regfile_q[r];
    q = READY;
    t = ren_tag_q[r];
    if (r == '0) begin
      v = '0;
    end else if (ren_valid_q[r]) begin
      if (done_q[t]) begin
        v = value_q[t];
      end else begin
        v = '0;
        q = RB_INDEX'(t);
`ifdef RB_LOOKUP_BYPASS_EN
        // Scan from the highest FU down so the lowest matching FU is kept.
        for (int i = FU_NUM - 1; i >= 0; i--) begin
          if (bus.valid_bus[i] && bus.RB_index_bus[i*RB_INDEX +: RB_INDEX] == RB_INDEX'(t)) begin
            v = bus.data_bus[i*WORD_SIZE +: WORD_SIZE];
            q = READY;
          end
        end
`endif
      end
    end
    return {v, q};
  endfunction

  assign {bus.vj, bus.qj} = lookup(bus.reg_numj);
  assign {bus.vk, bus.qk} = lookup(bus.reg_numk);

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    done_d         = done_q;
    dest_d         = dest_q;
    value_d        = value_q;
    ren_valid_d    = ren_valid_q;
    ren_tag_d      = ren_tag_q;
    regfile_d      = regfile_q;
    commit_valid_d = 1'b0;
    commit_reg_d   = commit_reg_q;
    commit_data_d  = commit_data_q;
    fu_tag         = '0;
    fu_ptr         = '0;

    alloc_fire = bus.alloc_req && bus.alloc_ready;
    // Decided on pre-edge done, so a result captured this cycle never commits
    // in the same cycle.
    do_commit  = busy_q[head_q] && done_q[head_q];

    // Result capture. Checking done_d lets the first FU to hit an entry claim
    // it; later FUs with the same tag see it as done and are dropped.
    for (int i = 0; i < FU_NUM; i++) begin
      fu_tag = bus.RB_index_bus[i*RB_INDEX +: RB_INDEX];
      if (bus.valid_bus[i] && fu_tag != NULL && fu_tag < SIZE_TAG) begin
        fu_ptr = fu_tag[PTR_W-1:0];
        if (busy_q[fu_ptr] && !done_d[fu_ptr]) begin
          done_d[fu_ptr]  = 1'b1;
          value_d[fu_ptr] = bus.data_bus[i*WORD_SIZE +: WORD_SIZE];
        end
      end
    end

    if (do_commit) begin
      commit_valid_d = 1'b1;
      commit_reg_d   = dest_q[head_q];
      commit_data_d  = value_q[head_q];
      if (dest_q[head_q] != '0) regfile_d[dest_q[head_q]] = value_q[head_q];
      // Only drop the mapping if no younger instruction renamed the register.
      if (ren_valid_q[dest_q[head_q]] && ren_tag_q[dest_q[head_q]] == head_q)
        ren_valid_d[dest_q[head_q]] = 1'b0;
      busy_d[head_q]  = 1'b0;
      done_d[head_q]  = 1'b0;
      dest_d[head_q]  = '0;
      value_d[head_q] = '0;
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end

    // Placed after commit so a same-register alloc overrides the clear above.
    if (alloc_fire) begin
      busy_d[tail_q]             = 1'b1;
      done_d[tail_q]             = 1'b0;
      dest_d[tail_q]             = bus.alloc_reg;
      value_d[tail_q]            = '0;
      ren_valid_d[bus.alloc_reg] = 1'b1;
      ren_tag_d[bus.alloc_reg]   = tail_q;
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end

    case ({alloc_fire, do_commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      ren_valid_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
      for (int e = 0; e < RB_SIZE; e++) begin
        dest_q[e]  <= '0;
        value_q[e] <= '0;
      end
      for (int r = 0; r < REG_NUM; r++) begin
        ren_tag_q[r] <= '0;
        regfile_q[r] <= '0;
      end
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      dest_q         <= dest_d;
      value_q        <= value_d;
      ren_valid_q    <= ren_valid_d;
      ren_tag_q      <= ren_tag_d;
      regfile_q      <= regfile_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_data_q  <= commit_data_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed bench for reorder_buffer. A queue-based program-order model of the
// buffer predicts every output; it is compared on each cycle, and literal
// expectations pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int W  = 32;
  localparam int RI = 4;
  localparam int RS = 8;
  localparam int FN = 4;
  localparam int RG = 5;
  localparam logic [RI-1:0] READY = 4'hF;
  localparam logic [RI-1:0] NULLT = 4'hE;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.WORD_SIZE(W), .RB_INDEX(RI), .RB_SIZE(RS), .FU_NUM(FN), .REG_INDEX(RG)) bus ();

  reorder_buffer #(.WORD_SIZE(W), .RB_INDEX(RI), .RB_SIZE(RS), .READY(READY), .NULL(NULLT),
                   .FU_NUM(FN), .REG_INDEX(RG), .REG_NUM(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic [2:0]   tag;
    logic [RG-1:0] rd;
    logic         done;
    logic [W-1:0] val;
  } ent_t;

  ent_t          rob[$];          // in-flight entries, oldest first
  logic [W-1:0]  m_rf [32];
  int            m_next;
  logic          m_cv;
  logic [RG-1:0] m_creg;
  logic [W-1:0]  exp_q[$];        // expected commit data

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rob.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_next = 0;
    m_cv   = 1'b0;
    m_creg = '0;
  endtask

  // Youngest in-flight writer of r decides the answer.
  task automatic m_lookup(input logic [RG-1:0] r, output logic [W-1:0] v, output logic [RI-1:0] q);
    int idx;
    bit hit;
    idx = -1;
    hit = 0;
    v = m_rf[r];
    q = READY;
    if (r == 0) begin
      v = '0;
      return;
    end
    for (int i = rob.size() - 1; i >= 0; i--) begin
      if (rob[i].rd == r) begin
        idx = i;
        break;
      end
    end
    if (idx >= 0) begin
      if (rob[idx].done) begin
        v = rob[idx].val;
      end else begin
        v = '0;
        q = {1'b0, rob[idx].tag};
`ifdef RB_LOOKUP_BYPASS_EN
        for (int f = 0; f < FN; f++) begin
          if (!hit && bus.valid_bus[f] && bus.RB_index_bus[f*RI +: RI] == {1'b0, rob[idx].tag}) begin
            hit = 1;
            v = bus.data_bus[f*W +: W];
            q = READY;
          end
        end
`endif
      end
    end
  endtask

  // Advance the model across the coming rising edge using current inputs.
  task automatic model_step();
    bit            commit_now;
    bit            alloc_now;
    logic [RI-1:0] t;
    ent_t          e;
    if (reset) begin
      model_reset();
      return;
    end
    commit_now = (rob.size() > 0) && rob[0].done;
    alloc_now  = bus.alloc_req && (rob.size() < RS);
    for (int f = 0; f < FN; f++) begin
      t = bus.RB_index_bus[f*RI +: RI];
      if (bus.valid_bus[f] && t != NULLT && t < RS) begin
        for (int j = 0; j < rob.size(); j++) begin
          if (rob[j].tag == t[2:0]) begin
            if (!rob[j].done) begin
              e = rob[j];
              e.done = 1'b1;
              e.val  = bus.data_bus[f*W +: W];
              rob[j] = e;
            end
            break;
          end
        end
      end
    end
    m_cv = commit_now;
    if (commit_now) begin
      e = rob.pop_front();
      m_creg = e.rd;
      exp_q.push_back(e.val);
      if (e.rd != 0) m_rf[e.rd] = e.val;
    end
    if (alloc_now) begin
      e.tag  = 3'(m_next);
      e.rd   = bus.alloc_reg;
      e.done = 1'b0;
      e.val  = '0;
      rob.push_back(e);
      m_next = (m_next + 1) % RS;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic compare();
    logic [RS-1:0]   ecv;
    logic [W*RS-1:0] ecd;
    logic [W-1:0]    v;
    logic [RI-1:0]   q;
    logic [W-1:0]    cd;
    ecv = '0;
    ecd = '0;
    foreach (rob[i]) begin
      ecd[rob[i].tag*W +: W] = rob[i].val;
      if (rob[i].done) ecv[rob[i].tag] = 1'b1;
    end
    check("alloc_ready", 256'(bus.alloc_ready), 256'(rob.size() < RS));
    check("alloc_index", 256'(bus.alloc_index), 256'(m_next));
    check("empty", 256'(bus.empty), 256'(rob.size() == 0));
    check("cdb_valid", 256'(bus.CDB_data_valid), 256'(ecv));
    check("cdb_data", 256'(bus.CDB_data_data), 256'(ecd));
    m_lookup(bus.reg_numj, v, q);
    check("vj", 256'(bus.vj), 256'(v));
    check("qj", 256'(bus.qj), 256'(q));
    m_lookup(bus.reg_numk, v, q);
    check("vk", 256'(bus.vk), 256'(v));
    check("qk", 256'(bus.qk), 256'(q));
    check("commit_valid", 256'(bus.commit_valid), 256'(m_cv));
    if (m_cv) begin
      cd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("commit_reg", 256'(bus.commit_reg), 256'(m_creg));
      check("commit_data", 256'(bus.commit_data), 256'(cd));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_req    = 1'b0;
    bus.alloc_reg    = '0;
    bus.valid_bus    = '0;
    bus.RB_index_bus = '0;
    bus.data_bus     = '0;
  endtask

  task automatic alloc(input logic [RG-1:0] r);
    bus.alloc_req = 1'b1;
    bus.alloc_reg = r;
  endtask

  task automatic fu(input int f, input logic [RI-1:0] tag, input logic [W-1:0] d);
    bus.valid_bus[f]             = 1'b1;
    bus.RB_index_bus[f*RI +: RI] = tag;
    bus.data_bus[f*W +: W]       = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    bus.reg_numj = '0;
    bus.reg_numk = '0;
    model_reset();

    // Reset with alloc_req held high.
    bus.alloc_req = 1'b1;
    bus.alloc_reg = 5'd5;
    @(negedge clk);
    step();
    step();
    #1;
    check("rst_alloc_ready", 256'(bus.alloc_ready), 256'(1));
    check("rst_alloc_index", 256'(bus.alloc_index), 256'(0));
    check("rst_empty", 256'(bus.empty), 256'(1));
    check("rst_cdb_valid", 256'(bus.CDB_data_valid), 256'(0));
    check("rst_commit_valid", 256'(bus.commit_valid), 256'(0));
    idle();
    reset = 1'b0;

    // Single instruction: alloc r3, FU1 returns 42, commit.
    alloc(5'd3);
    bus.reg_numj = 5'd3;
    step();
    idle();
    #1;
    check("t2_qj_tag0", 256'(bus.qj), 256'(0));
    fu(1, 4'd0, 32'd42);
    step();
    idle();
    #1;
    check("t2_cdb_valid0", 256'(bus.CDB_data_valid[0]), 256'(1));
    check("t2_vj_done", 256'(bus.vj), 256'(42));
    check("t2_qj_ready", 256'(bus.qj), 256'(READY));
    step();
    #1;
    check("t2_commit_valid", 256'(bus.commit_valid), 256'(1));
    check("t2_commit_reg", 256'(bus.commit_reg), 256'(3));
    check("t2_commit_data", 256'(bus.commit_data), 256'(42));
    check("t2_vj_rf", 256'(bus.vj), 256'(42));
    check("t2_qj_rf", 256'(bus.qj), 256'(READY));
    step();
    #1;
    check("t2_commit_pulse", 256'(bus.commit_valid), 256'(0));
    step();

    // Out-of-order completion, in-order commit.
    do_reset();
    alloc(5'd5);
    step();
    alloc(5'd6);
    bus.reg_numk = 5'd6;
    step();
    idle();
    fu(1, 4'd1, 32'd7);
    step();
    idle();
    #1;
    check("t3_no_commit", 256'(bus.commit_valid), 256'(0));
    check("t3_cdb_valid", 256'(bus.CDB_data_valid), 256'(8'h02));
    step();
    fu(0, 4'd0, 32'd9);
    step();
    idle();
    step();
    #1;
    check("t3_c1_valid", 256'(bus.commit_valid), 256'(1));
    check("t3_c1_reg", 256'(bus.commit_reg), 256'(5));
    check("t3_c1_data", 256'(bus.commit_data), 256'(9));
    step();
    #1;
    check("t3_c2_valid", 256'(bus.commit_valid), 256'(1));
    check("t3_c2_reg", 256'(bus.commit_reg), 256'(6));
    check("t3_c2_data", 256'(bus.commit_data), 256'(7));
    step();
    #1;
    check("t3_done_valid", 256'(bus.commit_valid), 256'(0));
    check("t3_empty", 256'(bus.empty), 256'(1));
    step();

    // Fill, overflow request ignored, commit frees slot next cycle, tail wraps.
    do_reset();
    for (int i = 0; i < RS; i++) begin
      alloc(5'(i + 1));
      step();
    end
    alloc(5'd9);
    #1;
    check("t4_full_ready", 256'(bus.alloc_ready), 256'(0));
    check("t4_full_index", 256'(bus.alloc_index), 256'(0));
    check("t4_full_empty", 256'(bus.empty), 256'(0));
    step();
    fu(0, 4'd0, 32'd100);
    step();
    bus.valid_bus = '0;
    step();
    #1;
    check("t4_commit_valid", 256'(bus.commit_valid), 256'(1));
    check("t4_commit_reg", 256'(bus.commit_reg), 256'(1));
    check("t4_ready_after", 256'(bus.alloc_ready), 256'(1));
    check("t4_index_wrap", 256'(bus.alloc_index), 256'(0));
    step();
    #1;
    check("t4_refull_ready", 256'(bus.alloc_ready), 256'(0));
    check("t4_refull_index", 256'(bus.alloc_index), 256'(1));
    idle();
    bus.reg_numj = 5'd9;
    #1;
    check("t4_qj_r9", 256'(bus.qj), 256'(0));
    step();

    // Rename kept by younger writer; duplicate tag results, lowest FU wins.
    do_reset();
    alloc(5'd2);
    step();
    alloc(5'd2);
    step();
    idle();
    fu(0, 4'd0, 32'd5);
    step();
    idle();
    step();
    bus.reg_numj = 5'd2;
    bus.reg_numk = 5'd0;
    #1;
    check("t5_commit_data", 256'(bus.commit_data), 256'(5));
    check("t5_qj_tag1", 256'(bus.qj), 256'(1));
    check("t5_vk_r0", 256'(bus.vk), 256'(0));
    check("t5_qk_r0", 256'(bus.qk), 256'(READY));
    fu(0, 4'd1, 32'd11);
    fu(1, NULLT, 32'd33);
    fu(2, 4'd1, 32'd22);
    fu(3, 4'd5, 32'd77);
    step();
    idle();
    #1;
    check("t5_cdb_slice1", 256'(bus.CDB_data_data[W +: W]), 256'(11));
    check("t5_vj_11", 256'(bus.vj), 256'(11));
    step();
    #1;
    check("t5_commit2_data", 256'(bus.commit_data), 256'(11));
    step();
    #1;
    check("t5_rf_r2", 256'(bus.vj), 256'(11));
    step();

    // Alloc and commit of the same register in one cycle.
    do_reset();
    alloc(5'd7);
    step();
    idle();
    fu(0, 4'd0, 32'd3);
    step();
    idle();
    alloc(5'd7);
    step();
    idle();
    bus.reg_numj = 5'd7;
    #1;
    check("t8_commit_data", 256'(bus.commit_data), 256'(3));
    check("t8_qj_new_tag", 256'(bus.qj), 256'(1));
    check("t8_index", 256'(bus.alloc_index), 256'(2));
    check("t8_empty", 256'(bus.empty), 256'(0));
    step();

    // Same-cycle lookup while the FU result arrives.
    do_reset();
    alloc(5'd4);
    step();
    idle();
    bus.reg_numj = 5'd4;
    fu(0, 4'd0, 32'd99);
    #1;
`ifdef RB_LOOKUP_BYPASS_EN
    check("t6_bypass_vj", 256'(bus.vj), 256'(99));
    check("t6_bypass_qj", 256'(bus.qj), 256'(READY));
`else
    check("t6_nobypass_qj", 256'(bus.qj), 256'(0));
    check("t6_nobypass_vj", 256'(bus.vj), 256'(0));
`endif
    step();
    idle();
    step();
    step();

    // Reset mid-operation right before a commit edge.
    do_reset();
    alloc(5'd1);
    step();
    idle();
    fu(0, 4'd0, 32'd8);
    step();
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    check("t7_rst_empty", 256'(bus.empty), 256'(1));
    check("t7_rst_cdb", 256'(bus.CDB_data_valid), 256'(0));
    step();
    #1;
    check("t7_rst_no_commit", 256'(bus.commit_valid), 256'(0));
    reset = 1'b0;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 120; c++) begin
      int pick;
      idle();
      bus.alloc_req = 1'($urandom_range(0, 1));
      bus.alloc_reg = 5'($urandom_range(0, 7));
      bus.reg_numj  = 5'($urandom_range(0, 7));
      bus.reg_numk  = 5'($urandom_range(0, 7));
      for (int f = 0; f < FN; f++) begin
        if ($urandom_range(0, 2) == 0) begin
          pick = $urandom_range(0, 9);
          fu(f, (pick < 8) ? 4'(pick) : ((pick == 8) ? NULLT : 4'd9), $urandom);
        end
      end
      step();
    end
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
